pu_or1k_wb_cappuccino: RTL

//  Writeback stage of the cappuccino pipeline, directly upstream of the register-file/bypass block.

---
 rtl/pu_or1k_wb_pkg.sv | 16 +
 rtl/pu_or1k_wb_load_align.sv | 42 ++++
 rtl/pu_or1k_wb_cappuccino.sv | 105 ++++++++++
 3 files changed

// File: rtl/pu_or1k_wb_pkg.sv
// Shared definitions for the cappuccino writeback stage: LSU access lengths
// and the writeback result-source select.
package pu_or1k_wb_pkg;

    localparam logic [1:0] LSU_BYTE = 2'b00;
    localparam logic [1:0] LSU_HALF = 2'b01;
    localparam logic [1:0] LSU_WORD = 2'b10;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'd0,
        SEL_LOAD = 2'd1,
        SEL_MUL  = 2'd2,
        SEL_SPR  = 2'd3
    } wb_sel_t;

endpackage

// File: rtl/pu_or1k_wb_load_align.sv
// Big-endian lane select and sign/zero extension of raw LSU read data.
// Only instantiated when PU_OR1K_WB_LSU_ALIGN_EN is defined.
module pu_or1k_wb_load_align
    import pu_or1k_wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] lsu_data,
    input  logic [1:0]        length,
    input  logic              zext,
    input  logic [1:0]        adr,
    output logic [DATA_W-1:0] load_data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic        byte_sign;
    logic        half_sign;

    always_comb begin
        unique case (adr)
            2'b00:   byte_val = lsu_data[31:24];
            2'b01:   byte_val = lsu_data[23:16];
            2'b10:   byte_val = lsu_data[15:8];
            default: byte_val = lsu_data[7:0];
        endcase
        // Halfword lanes follow adr[1] only; a misaligned adr[0] is not faulted here.
        half_val  = adr[1] ? lsu_data[15:0] : lsu_data[31:16];
        byte_sign = !zext && byte_val[7];
        half_sign = !zext && half_val[15];
    end

    always_comb begin
        load_data = lsu_data;
        case (length)
            LSU_BYTE: load_data = {{(DATA_W-8){byte_sign}}, byte_val};
            LSU_HALF: load_data = {{(DATA_W-16){half_sign}}, half_val};
            default:  load_data = lsu_data;
        endcase
    end

endmodule

// File: rtl/pu_or1k_wb_cappuccino.sv
// Cappuccino writeback stage: registers the ctrl result, drives the RF write port
// and bypass, and counts retired instructions. Optional macro: PU_OR1K_WB_LSU_ALIGN_EN.
module pu_or1k_wb_cappuccino
    import pu_or1k_wb_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH     = 32,
    parameter int OPTION_RF_ADDR_WIDTH     = 5,
    parameter int OPTION_R0_WRITE_SUPPRESS = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            padv_ctrl_i,
    input  logic                            pipeline_flush_i,
    input  logic                            ctrl_valid_i,
    input  logic                            ctrl_rf_wb_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] ctrl_rfd_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_alu_result_i,
    input  logic                            ctrl_op_lsu_load_i,
    input  logic [1:0]                      ctrl_lsu_length_i,
    input  logic                            ctrl_lsu_zext_i,
    input  logic [1:0]                      ctrl_lsu_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] lsu_result_i,
    input  logic                            ctrl_op_mul_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] mul_result_i,
    input  logic                            ctrl_op_mfspr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] mfspr_dat_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] result_o,
    output logic                            wb_rf_wb_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_o,
    output logic [31:0]                     retire_cnt_o
);

    logic                            capture;
    logic                            suppress_r0;
    wb_sel_t                         sel;
    logic [OPTION_OPERAND_WIDTH-1:0] load_data;
    logic [OPTION_OPERAND_WIDTH-1:0] pre_result;

    logic [OPTION_OPERAND_WIDTH-1:0] result_p1;
    logic [OPTION_RF_ADDR_WIDTH-1:0] adr_p1;
    logic                            rf_wb_p1;
    logic                            mul_p1;
    logic [31:0]                     retire_cnt;

`ifdef PU_OR1K_WB_LSU_ALIGN_EN
    pu_or1k_wb_load_align #(
        .DATA_W (OPTION_OPERAND_WIDTH)
    ) u_load_align (
        .lsu_data  (lsu_result_i),
        .length    (ctrl_lsu_length_i),
        .zext      (ctrl_lsu_zext_i),
        .adr       (ctrl_lsu_adr_i),
        .load_data (load_data)
    );
`else
    // The LSU already returns aligned, extended data in this build.
    logic unused_lsu_ctrl;
    assign unused_lsu_ctrl = ^{ctrl_lsu_length_i, ctrl_lsu_zext_i, ctrl_lsu_adr_i};
    assign load_data       = lsu_result_i;
`endif

    // Ctrl side: qualify the advance and pre-select the result source.
    assign capture     = padv_ctrl_i && ctrl_valid_i && !pipeline_flush_i;
    assign suppress_r0 = (OPTION_R0_WRITE_SUPPRESS != 0) && (ctrl_rfd_adr_i == '0);

    always_comb begin
        sel        = SEL_ALU;
        pre_result = ctrl_alu_result_i;
        if (ctrl_op_lsu_load_i) begin
            sel        = SEL_LOAD;
            pre_result = load_data;
        end else if (ctrl_op_mfspr_i) begin
            sel        = SEL_SPR;
            pre_result = mfspr_dat_i;
        end else if (ctrl_op_mul_i) begin
            sel        = SEL_MUL;
        end
    end

    // Ctrl -> wb register boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_p1  <= '0;
            adr_p1     <= '0;
            rf_wb_p1   <= 1'b0;
            mul_p1     <= 1'b0;
            retire_cnt <= '0;
        end else begin
            rf_wb_p1 <= capture && ctrl_rf_wb_i && !suppress_r0;
            if (capture) begin
                result_p1  <= pre_result;
                adr_p1     <= ctrl_rfd_adr_i;
                mul_p1     <= (sel == SEL_MUL);
                retire_cnt <= retire_cnt + 32'd1;
            end
        end
    end

    // Multiplier output only settles in the wb cycle, so it bypasses the register.
    assign result_o     = mul_p1 ? mul_result_i : result_p1;
    assign wb_rf_wb_o   = rf_wb_p1;
    assign wb_rfd_adr_o = adr_p1;
    assign retire_cnt_o = retire_cnt;

endmodule
